// File: rtl/alu_issue_stage.sv
// EX issue stage: holds one decoded instruction, forwards MEM/WB results onto
// its operands, and inserts a single bubble on a load-use hazard.
module alu_issue_stage #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DWIDTH-1:0] id_rs1_val,
  input  logic [DWIDTH-1:0] id_rs2_val,
  input  logic [DWIDTH-1:0] id_imm,
  input  logic [DWIDTH-1:0] id_pc,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic              id_reg_we,
  input  logic              id_is_load,
  input  logic              id_a_sel,
  input  logic              id_b_sel,
  input  logic [3:0]        id_alu_ctrl,

  input  logic              mem_reg_we,
  input  logic [4:0]        mem_rd_addr,
  input  logic [DWIDTH-1:0] mem_result,
  input  logic              wb_reg_we,
  input  logic [4:0]        wb_rd_addr,
  input  logic [DWIDTH-1:0] wb_result,

  input  logic              flush,
  input  logic              ex_ready,

  output logic              ex_valid,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  output logic [3:0]        alu_ctl,
  output logic [DWIDTH-1:0] ex_store_data,
  output logic [4:0]        ex_rd_addr,
  output logic              ex_reg_we,
  output logic              ex_is_load
);

  logic              valid_q;
  logic [DWIDTH-1:0] rs1_val_q;
  logic [DWIDTH-1:0] rs2_val_q;
  logic [DWIDTH-1:0] imm_q;
  logic [DWIDTH-1:0] pc_q;
  logic [4:0]        rs1_addr_q;
  logic [4:0]        rs2_addr_q;
  logic [4:0]        rd_addr_q;
  logic              reg_we_q;
  logic              is_load_q;
  logic              a_sel_q;
  logic              b_sel_q;
  logic [3:0]        alu_ctrl_q;

  logic [DWIDTH-1:0] rs1_fwd;
  logic [DWIDTH-1:0] rs2_fwd;
  logic              hazard;
  logic              advance;
  logic              accept;

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    rs1_fwd = rs1_val_q;
    if (rs1_addr_q != 5'd0 && mem_reg_we && mem_rd_addr == rs1_addr_q)
      rs1_fwd = mem_result;
    else if (rs1_addr_q != 5'd0 && wb_reg_we && wb_rd_addr == rs1_addr_q)
      rs1_fwd = wb_result;
  end

  always_comb begin
    rs2_fwd = rs2_val_q;
    if (rs2_addr_q != 5'd0 && mem_reg_we && mem_rd_addr == rs2_addr_q)
      rs2_fwd = mem_result;
    else if (rs2_addr_q != 5'd0 && wb_reg_we && wb_rd_addr == rs2_addr_q)
      rs2_fwd = wb_result;
  end

  // Both source addresses are compared even if the operand is unused.
  always_comb begin
    hazard = valid_q && is_load_q && (rd_addr_q != 5'd0) &&
             ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));
  end

  assign advance  = ex_ready || !valid_q;
  assign id_ready = advance && !hazard && !flush;
  assign accept   = id_valid && id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      rd_addr_q  <= 5'd0;
      reg_we_q   <= 1'b0;
      is_load_q  <= 1'b0;
      a_sel_q    <= 1'b0;
      b_sel_q    <= 1'b0;
      alu_ctrl_q <= 4'd0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      rs1_val_q  <= id_rs1_val;
      rs2_val_q  <= id_rs2_val;
      imm_q      <= id_imm;
      pc_q       <= id_pc;
      rs1_addr_q <= id_rs1_addr;
      rs2_addr_q <= id_rs2_addr;
      rd_addr_q  <= id_rd_addr;
      reg_we_q   <= id_reg_we;
      is_load_q  <= id_is_load;
      a_sel_q    <= id_a_sel;
      b_sel_q    <= id_b_sel;
      alu_ctrl_q <= id_alu_ctrl;
    end else if (advance) begin
      valid_q <= 1'b0;
    end else begin
      // Held: capture forwarded operands before the producer retires.
      rs1_val_q <= rs1_fwd;
      rs2_val_q <= rs2_fwd;
    end
  end

  assign ex_valid      = valid_q;
  assign alu_a         = a_sel_q ? pc_q : rs1_fwd;
  assign alu_b         = b_sel_q ? imm_q : rs2_fwd;
  assign alu_ctl       = alu_ctrl_q;
  assign ex_store_data = rs2_fwd;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_we     = valid_q && reg_we_q;
  assign ex_is_load    = valid_q && is_load_q;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, datapath width.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: id_valid  input  1  decode presents an instruction.
REQ-005 SHALL have ports: id_ready  output  1  stage accepts the decode instruction this cycle.
REQ-006 SHALL have ports: id_rs1_val, id_rs2_val, id_imm, id_pc  input  DWIDTH each  register-file reads, immediate, PC.
REQ-007 SHALL have ports: id_rs1_addr, id_rs2_addr, id_rd_addr  input  5 each  register indices.
REQ-008 SHALL have ports: id_reg_we, id_is_load, id_a_sel, id_b_sel  input  1 each  writeback enable, load flag, A source (0 rs1, 1 pc), B source (0 rs2, 1 imm).
REQ-009 SHALL have ports: id_alu_ctrl  input  4  ALU control code from ALUCtrl.
REQ-010 SHALL have ports: mem_reg_we, wb_reg_we  input  1 each; mem_rd_addr, wb_rd_addr  input  5 each; mem_result, wb_result  input  DWIDTH each  forwarding sources.
REQ-011 SHALL have ports: flush  input  1  kill the EX-held instruction and the decode offer.
REQ-012 SHALL have ports: ex_ready  input  1  downstream accepts the EX instruction.
REQ-013 SHALL have ports: ex_valid  output  1; alu_a, alu_b  output  DWIDTH; alu_ctl  output  4; ex_store_data  output  DWIDTH; ex_rd_addr  output  5; ex_reg_we, ex_is_load  output  1 each.

Function
REQ-014 SHALL hold one instruction in EX registers: valid, rs1/rs2 values, imm, pc, rs addresses, rd, reg_we, is_load, a_sel, b_sel, alu_ctrl.
REQ-015 SHALL compute forwarded rs1 and rs2 combinationally, per operand: MEM match (mem_reg_we=1, mem_rd_addr equal to the operand address, address nonzero) takes priority; otherwise WB match under the same rule; otherwise the latched value.
REQ-016 SHALL never forward onto address x0.
REQ-017 SHALL drive alu_a as pc if a_sel=1, else forwarded rs1.
REQ-018 SHALL drive alu_b as imm if b_sel=1, else forwarded rs2.
REQ-019 SHALL drive ex_store_data as forwarded rs2, and alu_ctl as the latched alu_ctrl.
REQ-020 SHALL detect a load-use hazard when ex_valid=1, ex_is_load=1, ex_rd_addr is nonzero, and ex_rd_addr equals id_rs1_addr or id_rs2_addr; both addresses SHALL be compared regardless of a_sel/b_sel.
REQ-021 SHALL drive id_ready = (ex_ready OR NOT ex_valid) AND NOT hazard AND NOT flush.
REQ-022 SHALL load the EX registers from the decode inputs on a clock edge when id_valid=1 and id_ready=1, with ex_valid becoming 1 one cycle after acceptance (latency 1).
REQ-023 SHALL clear ex_valid (insert a bubble) on an edge where the EX slot advances (ex_ready=1 or ex_valid=0) but no instruction is accepted; this includes a hazard, giving exactly one bubble per load-use.
REQ-024 SHALL hold all EX registers while ex_valid=1 and ex_ready=0, with one exception: on every held edge, latched rs1 and rs2 values SHALL be overwritten with their forwarded values, so that forwarded data retiring from MEM or WB is not lost.
REQ-025 SHALL, on flush=1, clear ex_valid at the next edge and accept nothing that cycle; flush SHALL have priority over hold, hazard and accept.
REQ-026 SHALL keep ex_reg_we and ex_is_load gated: both outputs SHALL be 0 whenever ex_valid=0.
REQ-027 SHALL use wrap-free pass-through widths; no arithmetic in this block.

Reset
REQ-028 SHALL, while rst=1 regardless of clk, force ex_valid=0 and clear all EX registers to 0, so that alu_a, alu_b, alu_ctl, ex_store_data, ex_rd_addr, ex_reg_we and ex_is_load read 0 when no forward is active.
REQ-029 SHALL, on rst asserting mid-stall or mid-hazard, discard the held instruction; after release the first accepted instruction issues with no residual bubble.

Verification
REQ-030 SHALL cover: simple issue. Accept ADD with rs1_val=5, rs2_val=7, b_sel=0 -> next cycle ex_valid=1, alu_a=5, alu_b=7, alu_ctl=ADD.
REQ-031 SHALL cover: forwarding priority. rs1=x3 with mem_rd=x3 (mem_result=0x11) and wb_rd=x3 (wb_result=0x22) -> alu_a=0x11; with only wb_rd=x3 -> alu_a=0x22; with rd=x0 -> no forward.
REQ-032 SHALL cover: load-use. EX holds load to x5, decode reads x5 -> id_ready=0 for one cycle, ex_valid=0 the next cycle, then the consumer issues.
REQ-033 SHALL cover: stall with retiring forward. ex_ready=0 while wb forwards 0xAB to rs2 for one cycle -> after wb_reg_we drops, ex_store_data stays 0xAB.
REQ-034 SHALL cover: flush. flush=1 with id_valid=1 and ex_valid=1 -> id_ready=0, ex_valid=0 next cycle, ex_reg_we=0.
REQ-035 SHALL cover: asynchronous reset. rst pulsed between clock edges during a stall -> ex_valid=0 immediately and all outputs 0.
